gc_controller: RTL and testbench

GC_CONTROLLER -- requirements
Module: gc_controller

---
 rtl/gc_controller.sv | 129 ++++++++++++
 tb/tb_gc_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gc_controller.sv
// gc_controller: garbage-collection pass sequencer with per-block invalid-page tracking
module gc_controller #(
  parameter int NBLK = 16,
  parameter int PPB = 64,
  parameter int GC_THRESH = PPB / 2,
  localparam int BW = $clog2(NBLK),
  localparam int CW = $clog2(PPB + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          gc_start,
  input  logic          invalid_flag,
  input  logic [BW-1:0] invalid_blk,
  input  logic [BW-1:0] active_blk,
  input  logic          active_request,
  input  logic          move_done_flag,
  input  logic          erase_ack,
  output logic [BW-1:0] erase_blk,
  output logic          move_flag,
  output logic          erase_req,
  output logic          gc_busy,
  output logic          gc_interrupt,
  output logic          request_done,
  output logic          no_victim
);
  typedef enum logic [2:0] {IDLE, SCAN, MOVE, WAIT_MV, PAUSE, ERASE, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q [NBLK];
  logic [CW-1:0] cnt_d [NBLK];
  logic [BW-1:0] idx_q, idx_d, bidx_q, bidx_d, eblk_q, eblk_d, scan_bidx;
  logic [CW-1:0] best_q, best_d, mv_q, mv_d, scan_best, mv_left, mv_dec;
  logic mf_q, mf_d, er_q, er_d, busy_q, busy_d, int_q, int_d, done_q, done_d, nv_q, nv_d;
  logic last, take, hold, found;
  // next-state, counter bookkeeping and registered output values
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    best_d = best_q;
    bidx_d = bidx_q;
    eblk_d = eblk_q;
    mv_d = mv_q;
    cnt_d = cnt_q;
    last = idx_q == BW'(NBLK - 1);
    take = idx_q != active_blk && cnt_q[idx_q] > best_q;
    scan_best = take ? cnt_q[idx_q] : best_q;
    scan_bidx = take ? idx_q : bidx_q;
    found = int'(scan_best) >= GC_THRESH;
    mv_left = CW'(PPB) - scan_best;
    mv_dec = mv_q - 1'b1;
    hold = state_q inside {MOVE, WAIT_MV, PAUSE, ERASE, DONE};
    for (int i = 0; i < NBLK; i++)
      if (invalid_flag && invalid_blk == BW'(i) && !(hold && eblk_q == BW'(i)) && cnt_q[i] != CW'(PPB))
        cnt_d[i] = cnt_q[i] + 1'b1;
    case (state_q)
      IDLE: if (gc_start) begin
        state_d = SCAN;
        idx_d = '0;
        best_d = '0;
        bidx_d = '0;
      end
      SCAN: begin
        idx_d = idx_q + 1'b1;
        best_d = scan_best;
        bidx_d = scan_bidx;
        if (last) begin
          state_d = !found ? IDLE : mv_left == '0 ? ERASE : MOVE;
          eblk_d = found ? scan_bidx : eblk_q;
          mv_d = found ? mv_left : mv_q;
        end
      end
      MOVE: state_d = active_request ? PAUSE : WAIT_MV;
      WAIT_MV: if (move_done_flag) begin
        mv_d = mv_dec;
        state_d = mv_dec == '0 ? ERASE : MOVE;
      end
      PAUSE: state_d = active_request ? PAUSE : MOVE;
      ERASE: if (erase_ack) begin
        cnt_d[eblk_q] = '0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    mf_d = state_d == WAIT_MV;
    er_d = state_d == ERASE;
    busy_d = state_d != IDLE;
    int_d = state_d == PAUSE;
    done_d = state_d == DONE;
    nv_d = state_q == SCAN && last && !found;
  end
  // state, counters and outputs, cleared asynchronously
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q <= '{default: '0};
      idx_q <= '0;
      best_q <= '0;
      bidx_q <= '0;
      eblk_q <= '0;
      mv_q <= '0;
      mf_q <= 1'b0;
      er_q <= 1'b0;
      busy_q <= 1'b0;
      int_q <= 1'b0;
      done_q <= 1'b0;
      nv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      best_q <= best_d;
      bidx_q <= bidx_d;
      eblk_q <= eblk_d;
      mv_q <= mv_d;
      mf_q <= mf_d;
      er_q <= er_d;
      busy_q <= busy_d;
      int_q <= int_d;
      done_q <= done_d;
      nv_q <= nv_d;
    end
  end
  assign erase_blk = eblk_q;
  assign move_flag = mf_q;
  assign erase_req = er_q;
  assign gc_busy = busy_q;
  assign gc_interrupt = int_q;
  assign request_done = done_q;
  assign no_victim = nv_q;
endmodule

// File: tb/tb_gc_controller.sv
// tb_gc_controller: randomized and directed checks of gc_controller against a count-table model
module tb_gc_controller;
  localparam int NBLK = 8;
  localparam int PPB = 8;
  localparam int TH = 4;
  logic CLK = 0, nRST = 1, gc_start = 0, invalid_flag = 0, active_request = 0;
  logic move_done_flag = 0, erase_ack = 0;
  logic [2:0] invalid_blk = 0, active_blk = 0, erase_blk;
  logic move_flag, erase_req, gc_busy, gc_interrupt, request_done, no_victim;
  int n_chk = 0, n_fail = 0;
  int mcnt [NBLK];

  gc_controller #(.NBLK(NBLK), .PPB(PPB), .GC_THRESH(TH)) dut (
    .CLK(CLK), .nRST(nRST), .gc_start(gc_start), .invalid_flag(invalid_flag),
    .invalid_blk(invalid_blk), .active_blk(active_blk), .active_request(active_request),
    .move_done_flag(move_done_flag), .erase_ack(erase_ack), .erase_blk(erase_blk),
    .move_flag(move_flag), .erase_req(erase_req), .gc_busy(gc_busy),
    .gc_interrupt(gc_interrupt), .request_done(request_done), .no_victim(no_victim)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    nRST = 0;
    #2;
    nRST = 1;
    for (int i = 0; i < NBLK; i++) mcnt[i] = 0;
    tick();
  endtask

  task automatic inv(input int b, input int n);
    for (int k = 0; k < n; k++) begin
      invalid_flag = 1;
      invalid_blk = 3'(b);
      tick();
      if (mcnt[b] < PPB) mcnt[b]++;
    end
    invalid_flag = 0;
  endtask

  task automatic check_cnts(input string tag);
    for (int i = 0; i < NBLK; i++) begin
      n_chk++;
      if (int'(dut.cnt_q[i]) !== mcnt[i]) begin
        n_fail++;
        $display("FAIL %s cnt[%0d]: got %0d expected %0d", tag, i, dut.cnt_q[i], mcnt[i]);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    n_chk++;
    if ({move_flag, erase_req, gc_busy, gc_interrupt, request_done, no_victim, erase_blk} !== 9'b0) begin
      n_fail++;
      $display("FAIL %s outputs: got mf=%b er=%b busy=%b int=%b done=%b nv=%b blk=%0d expected all 0",
               tag, move_flag, erase_req, gc_busy, gc_interrupt, request_done, no_victim, erase_blk);
    end
  endtask

  // One full pass driven from gc_start, with the model deciding victim and move count
  task automatic run_pass(input string tag, input int act, input int pause_mv, input int ack_delay);
    int best, vic, ev, exp_moves, moves, wt, ecnt, dn, nv, intr, nv_t, first_e, exp_intr;
    bit fin;
    best = -1; vic = -1;
    for (int i = 0; i < NBLK; i++)
      if (i != act && mcnt[i] > best) begin best = mcnt[i]; vic = i; end
    if (best < TH) vic = -1;
    exp_moves = vic >= 0 ? PPB - best : 0;
    exp_intr = (vic >= 0 && pause_mv > 0 && pause_mv <= exp_moves) ? 3 : 0;
    ev = vic < 0 ? 0 : vic;
    moves = 0; wt = 0; ecnt = 0; dn = 0; nv = 0; intr = 0; nv_t = -1; first_e = -1; fin = 0;
    active_blk = 3'(act);
    gc_start = 1;
    tick();
    n_chk++;
    if (gc_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_start: got %b expected 1", tag, gc_busy);
    end
    for (int t = 0; t < 300; t++) begin
      gc_start = 0; move_done_flag = 0; erase_ack = 0; invalid_flag = 0;
      if (move_flag && gc_interrupt) begin
        n_chk++; n_fail++;
        $display("FAIL %s move_during_pause: got move_flag=1 gc_interrupt=1 expected exclusive", tag);
      end
      if (gc_interrupt) begin
        intr++;
        if (intr == 3) active_request = 0;
      end
      if (move_flag) begin
        gc_start = 1;
        if (moves + 1 == pause_mv) active_request = 1;
        wt++;
        if (wt > ack_delay) begin move_done_flag = 1; moves++; wt = 0; end
      end
      if (erase_req) begin
        gc_start = 1;
        if (ecnt == 0) begin
          first_e = t;
          n_chk++;
          if (int'(erase_blk) !== vic) begin
            n_fail++;
            $display("FAIL %s erase_blk: got %0d expected %0d", tag, erase_blk, vic);
          end
        end
        ecnt++;
        invalid_flag = 1;
        if (ecnt > ack_delay) begin
          erase_ack = 1;
          invalid_blk = 3'((ev + 1) % NBLK);
          if (mcnt[(ev + 1) % NBLK] < PPB) mcnt[(ev + 1) % NBLK]++;
          mcnt[ev] = 0;
        end else invalid_blk = 3'(ev);
      end
      if (request_done) dn++;
      if (no_victim) begin nv++; nv_t = t; end
      if (!gc_busy) begin fin = 1; break; end
      tick();
    end
    gc_start = 0; move_done_flag = 0; erase_ack = 0; invalid_flag = 0; active_request = 0;
    n_chk++;
    if (!fin) begin n_fail++; $display("FAIL %s timeout: got busy after 300 cycles expected idle", tag); end
    n_chk++;
    if (moves !== exp_moves) begin n_fail++; $display("FAIL %s moves: got %0d expected %0d", tag, moves, exp_moves); end
    n_chk++;
    if (dn !== (vic >= 0 ? 1 : 0)) begin n_fail++; $display("FAIL %s request_done: got %0d pulses expected %0d", tag, dn, vic >= 0); end
    n_chk++;
    if (nv !== (vic < 0 ? 1 : 0)) begin n_fail++; $display("FAIL %s no_victim: got %0d pulses expected %0d", tag, nv, vic < 0); end
    n_chk++;
    if ((ecnt > 0) !== (vic >= 0)) begin n_fail++; $display("FAIL %s erase_seen: got %0d expected %0d", tag, ecnt > 0, vic >= 0); end
    n_chk++;
    if (intr !== exp_intr) begin n_fail++; $display("FAIL %s pause_cycles: got %0d expected %0d", tag, intr, exp_intr); end
    if (vic < 0) begin
      n_chk++;
      if (nv_t !== NBLK) begin n_fail++; $display("FAIL %s no_victim_time: got %0d expected %0d", tag, nv_t, NBLK); end
    end
    if (vic >= 0 && exp_moves == 0) begin
      n_chk++;
      if (first_e !== NBLK) begin n_fail++; $display("FAIL %s erase_time: got %0d expected %0d", tag, first_e, NBLK); end
    end
    check_cnts(tag);
  endtask

  task automatic test_reset();
    #1 nRST = 0;
    #1;
    check_idle_outputs("reset");
    for (int i = 0; i < NBLK; i++) mcnt[i] = 0;
    check_cnts("reset");
    tick();
    nRST = 1;
    tick();
  endtask

  task automatic test_basic();
    reset_dut();
    inv(3, 5);
    inv(5, 6);
    run_pass("basic", 0, 0, 1);
  endtask

  task automatic test_no_victim();
    reset_dut();
    inv(2, 3);
    run_pass("no_victim", 0, 0, 0);
  endtask

  task automatic test_full_block();
    reset_dut();
    inv(4, 10);
    run_pass("full_block", 0, 0, 2);
  endtask

  task automatic test_pause();
    reset_dut();
    inv(1, 5);
    run_pass("pause", 0, 1, 2);
  endtask

  task automatic test_active_skip();
    reset_dut();
    inv(6, 7);
    inv(1, 4);
    run_pass("active_skip", 6, 0, 1);
  endtask

  task automatic test_spurious();
    move_done_flag = 1;
    erase_ack = 1;
    tick();
    move_done_flag = 0;
    erase_ack = 0;
    tick();
    n_chk++;
    if ({gc_busy, move_flag, erase_req} !== 3'b0) begin
      n_fail++;
      $display("FAIL spurious: got busy=%b mf=%b er=%b expected 0", gc_busy, move_flag, erase_req);
    end
    check_cnts("spurious");
  endtask

  task automatic test_reset_mid();
    bit seen;
    reset_dut();
    inv(4, 8);
    seen = 0;
    gc_start = 1;
    tick();
    gc_start = 0;
    for (int t = 0; t < 30 && !seen; t++) begin
      if (erase_req) seen = 1;
      else tick();
    end
    n_chk++;
    if (!seen) begin n_fail++; $display("FAIL reset_mid erase_wait: got no erase_req expected one"); end
    nRST = 0;
    #1;
    check_idle_outputs("reset_mid");
    for (int i = 0; i < NBLK; i++) mcnt[i] = 0;
    check_cnts("reset_mid");
    #1 nRST = 1;
    tick();
    tick();
    check_idle_outputs("reset_mid_after");
    inv(2, 6);
    run_pass("reset_mid_restart", 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    reset_dut();
    inv(0, 6);
    inv(7, 5);
    run_pass("b2b_1", 3, 0, 0);
    run_pass("b2b_2", 3, 0, 0);
    run_pass("b2b_3", 3, 0, 0);
  endtask

  task automatic test_random();
    reset_dut();
    for (int it = 0; it < 10; it++) begin
      int n;
      n = $urandom_range(4, 20);
      for (int k = 0; k < n; k++) inv($urandom_range(0, NBLK - 1), $urandom_range(1, 3));
      run_pass("random", $urandom_range(0, NBLK - 1), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_victim();
    test_full_block();
    test_pause();
    test_active_skip();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
